// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-side bus grouping instruction memory, decode handshake and redirect
interface instruction_fetch_if;
    logic [31:0] imem_address;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halted;
    modport master (
        output imem_address, instr, instr_pc, instr_valid, halted,
        input  imem_data, instr_ready, branch_taken, branch_target
    );
    modport slave (
        input  imem_address, instr, instr_pc, instr_valid, halted,
        output imem_data, instr_ready, branch_taken, branch_target
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and prefetch queue feeding decode; FETCH_HALT_EN stops fetch on a zero word
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   word_d [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   addr_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          halt_q, halt_d;
    logic          pop, push, hit, enq;
    // Queue bookkeeping; a redirect flushes everything and suppresses that cycle's push and pop
    always_comb begin
        pop  = (count_q != '0) && bus.instr_ready;
        push = !halt_q && ((count_q != CW'(DEPTH)) || pop) && !bus.branch_taken;
`ifdef FETCH_HALT_EN
        hit  = push && (bus.imem_data == 32'h0);
`else
        hit  = 1'b0;
`endif
        enq  = push && !hit;
        word_d = word_q;
        addr_d = addr_q;
        if (enq) begin
            word_d[tail_q] = bus.imem_data;
            addr_d[tail_q] = pc_q;
        end
        pc_d    = bus.branch_taken ? (bus.branch_target & ~32'h3) : enq ? pc_q + 32'd4 : pc_q;
        head_d  = bus.branch_taken ? '0 : head_q + PW'(pop);
        tail_d  = bus.branch_taken ? '0 : tail_q + PW'(enq);
        count_d = bus.branch_taken ? '0 : count_q + CW'(enq) - CW'(pop);
        halt_d  = !bus.branch_taken && (halt_q || hit);
    end
    // State registers; queue storage needs no reset since count gates its visibility
    always_ff @(posedge clk) begin
        word_q <= word_d;
        addr_q <= addr_d;
        if (reset) begin
            pc_q    <= RESET_PC & ~32'h3;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            halt_q  <= halt_d;
        end
    end
    assign bus.imem_address = pc_q;
    assign bus.instr_valid  = count_q != '0;
    assign bus.instr        = (count_q != '0) ? word_q[head_q] : 32'h0;
    assign bus.instr_pc     = (count_q != '0) ? addr_q[head_q] : 32'h0;
`ifdef FETCH_HALT_EN
    assign bus.halted = halt_q;
`else
    assign bus.halted = 1'b0;
`endif
endmodule
